// File: rtl/song_pkg.sv
// Shared song sequencer definitions: default widths, markers, ROM field layout, state encoding.
// The GAP state exists only when NOTE_GAP_EN is defined.
package song_pkg;
    localparam int DEF_ADDR_W    = 5;
    localparam int DEF_SONG_W    = 2;
    localparam int DEF_NOTE_W    = 6;
    localparam int DEF_DUR_W     = 6;
    localparam int END_MARKER    = 0;
    localparam int REST          = 0;
    // rom_data = {note, duration}: duration in the low bits, note directly above it
    localparam int DUR_FIELD_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_WAIT_ROM = 3'd2,
        ST_PLAY     = 3'd3,
        ST_END      = 3'd4
`ifdef NOTE_GAP_EN
        ,
        ST_GAP      = 3'd5
`endif
    } state_t;
endpackage

// File: rtl/beat_duration_counter.sv
// Beat down-counter for the current note; last flags the beat that finishes the note.
module beat_duration_counter
    import song_pkg::*;
#(
    parameter int W = DEF_DUR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         last
);
    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] ZERO = {W{1'b0}};

    logic [W-1:0] count_r;
    logic [W-1:0] count_next_s;

    // next count: load a fresh duration or consume one beat, never below zero
    always_comb begin
        count_next_s = count_r;
        if (load) begin
            count_next_s = load_val;
        end else if (en && (count_r != ZERO)) begin
            count_next_s = count_r - ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    dff #(.W(W), .RST_VAL(ZERO)) u_count_reg (
        .clk   (clk),
        .reset (reset),
        .srst  (clear),
        .d     (count_next_s),
        .q     (count_r)
    );

    assign last = en && (count_r == ONE);
endmodule

// File: rtl/dff.sv
// Generic register: asynchronous active-high reset plus synchronous clear, both to RST_VAL.
module dff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         srst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    // state register, clear has priority over new data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RST_VAL;
        end else if (srst) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end
endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: walks a song ROM and holds each note for its beat count.
// Define NOTE_GAP_EN to insert a one-beat rest between consecutive notes.
module song_sequencer
    import song_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int SONG_W = DEF_SONG_W,
    parameter int NOTE_W = DEF_NOTE_W,
    parameter int DUR_W  = DEF_DUR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     play,
    input  logic                     restart,
    input  logic [SONG_W-1:0]        song_sel,
    input  logic                     beat,
    output logic [SONG_W+ADDR_W-1:0] rom_addr,
    input  logic [NOTE_W+DUR_W-1:0]  rom_data,
    output logic [NOTE_W-1:0]        note,
    output logic                     new_note,
    output logic                     playing,
    output logic                     song_done
);
    localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] IDX_LAST = {ADDR_W{1'b1}};
    localparam logic [NOTE_W-1:0] NOTE_REST = NOTE_W'(REST);
    localparam logic [DUR_W-1:0]  DUR_END   = DUR_W'(END_MARKER);

    state_t              state_r;
    logic [ADDR_W-1:0]   index_r;
    logic [SONG_W-1:0]   song_r;
    logic [ADDR_W-1:0]   next_index_s;
    logic [NOTE_W-1:0]   rom_note_s;
    logic [DUR_W-1:0]    rom_dur_s;
    logic                restart_s;
    logic                cnt_last_s;

    assign rom_dur_s    = rom_data[DUR_FIELD_LSB +: DUR_W];
    assign rom_note_s   = rom_data[DUR_FIELD_LSB + DUR_W +: NOTE_W];
    assign next_index_s = index_r + IDX_ONE;
    assign restart_s    = restart && (state_r != ST_IDLE);

    beat_duration_counter #(.W(DUR_W)) u_dur_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (restart_s),
        .load     ((state_r == ST_WAIT_ROM) && (rom_dur_s != DUR_END)),
        .load_val (rom_dur_s),
        .en       ((state_r == ST_PLAY) && play && beat),
        .last     (cnt_last_s)
    );

    // sequencer FSM; every output is a register updated here
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            index_r   <= IDX_ZERO;
            song_r    <= {SONG_W{1'b0}};
            rom_addr  <= {(SONG_W+ADDR_W){1'b0}};
            note      <= NOTE_REST;
            new_note  <= 1'b0;
            playing   <= 1'b0;
            song_done <= 1'b0;
        end else begin
            new_note <= 1'b0;
            playing  <= 1'b0;
            if (restart_s) begin
                // restart outranks any beat arriving in the same cycle
                song_r    <= song_sel;
                index_r   <= IDX_ZERO;
                rom_addr  <= {song_sel, IDX_ZERO};
                note      <= NOTE_REST;
                song_done <= 1'b0;
                state_r   <= ST_FETCH;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        note      <= NOTE_REST;
                        song_done <= 1'b0;
                        if (play) begin
                            song_r   <= song_sel;
                            index_r  <= IDX_ZERO;
                            rom_addr <= {song_sel, IDX_ZERO};
                            state_r  <= ST_FETCH;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_FETCH: begin
                        state_r <= ST_WAIT_ROM;
                    end
                    ST_WAIT_ROM: begin
                        if (rom_dur_s == DUR_END) begin
                            note      <= NOTE_REST;
                            song_done <= 1'b1;
                            state_r   <= ST_END;
                        end else begin
                            note     <= rom_note_s;
                            new_note <= 1'b1;
                            playing  <= play;
                            state_r  <= ST_PLAY;
                        end
                    end
                    ST_PLAY: begin
                        if (cnt_last_s) begin
                            if (index_r == IDX_LAST) begin
                                note      <= NOTE_REST;
                                song_done <= 1'b1;
                                state_r   <= ST_END;
                            end else begin
                                index_r <= next_index_s;
`ifdef NOTE_GAP_EN
                                note    <= NOTE_REST;
                                state_r <= ST_GAP;
`else
                                // old note stays audible while the next entry is fetched
                                rom_addr <= {song_r, next_index_s};
                                state_r  <= ST_FETCH;
`endif
                            end
                        end else begin
                            playing <= play;
                            state_r <= ST_PLAY;
                        end
                    end
`ifdef NOTE_GAP_EN
                    ST_GAP: begin
                        if (beat && play) begin
                            rom_addr <= {song_r, index_r};
                            state_r  <= ST_FETCH;
                        end else begin
                            state_r <= ST_GAP;
                        end
                    end
`endif
                    ST_END: begin
                        if (!play) begin
                            song_done <= 1'b0;
                            state_r   <= ST_IDLE;
                        end else begin
                            state_r <= ST_END;
                        end
                    end
                    default: begin
                        note      <= NOTE_REST;
                        song_done <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                endcase
            end
        end
    end
endmodule
